byte_lane_mem_responder: RTL and testbench
==========================================

Name: byte_lane_mem_responder

Overview:
- Memory-side responder for the core's byte-addressable memory port.
- Storage is four 8-bit byte-lane banks. Reads are continuous and registered, and may start at any byte address.
- Writes are 1, 2 or 4 bytes. They use a level handshake (write size held until done) and misalignment is reported.
- Instantiated at top level in place of the memory, wired to address/write/d0..d3/q0..q3/done/error.

Parameters:
- ADDR_BITS, 12, byte-address width actually decoded; memory size is 2^ADDR_BITS bytes.
- ROWS, 2^(ADDR_BITS-2), derived; rows per lane bank. Not overridable.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-low reset
- address  input  32  byte address A of the access
- write  input  2  0=none/read, 1=byte, 2=half, 3=word; held nonzero by the initiator until done is seen
- d0..d3  input  8 each  write data; d0 is the most-significant byte
- q0..q3  output  8 each  read data: q0=byte A, q1=A+1, q2=A+2, q3=A+3
- done  output  1  write-request complete; held high until write returns to 0
- error  output  1  the access was rejected (misaligned or out of range); qualified as described in Behaviour

Behaviour:
- Byte mapping:
  - byte address X lives in lane X[1:0], row X[ADDR_BITS-1:2].
  - A read at A fetches lane (A+k)[1:0], row (A+k)>>2 for k=0..3.
  - Bytes beyond the top address wrap modulo 2^ADDR_BITS.
- Reset (rst=0, async):
  - state=IDLE, done=0, error=0, q0..q3=0.
  - Bank contents are NOT reset.
- Reads:
  - q0..q3 are registered every clock from the current address; latency is 1 clock.
  - Updates continue in every state.
  - Read error flag: error<=1 when address out of range (see Optional Feature) and write==0; otherwise 0 in IDLE.
- Write data placement (big-endian lanes within the access):
  - byte: d3 -> A.
  - half: d2 -> A, d3 -> A+1.
  - word: d0 -> A, d1 -> A+1, d2 -> A+2, d3 -> A+3.
- Alignment:
  - half requires A[0]=0.
  - word requires A[1:0]=0.
  - byte is always aligned.
- FSM:
  - IDLE: write!=0 -> latch address, size and d0..d3 into request registers, go to CHECK.
  - CHECK:
    - Misaligned or out-of-range -> error<=1, done<=1, go to HOLD; no bank is written.
    - Otherwise -> COMMIT.
  - COMMIT: write the selected lanes from the latched request in one clock; done<=1, error<=0, go to HOLD.
  - HOLD: keep done and error; write==0 -> done<=0, error<=0, go to IDLE.
  - Illegal state encoding -> IDLE.
- Timing and hazards:
  - A write completes 3 clocks after write goes nonzero (IDLE->CHECK->COMMIT->HOLD, done visible in HOLD).
  - A read issued the clock after COMMIT returns the new data.
  - Inputs changing while in CHECK or COMMIT are ignored; the latched request is used.
  - In HOLD, a changed nonzero write value is not a new request. A new request needs write to return to 0 first.
  - Reset mid-write (CHECK or COMMIT): that write is aborted with no partial lane update guaranteed, then IDLE.

Optional Feature:
- Macro: RESP_BOUNDS_CHECK_EN.
- Defined: any address with bits 31:ADDR_BITS nonzero is out of range.
  - Writes: rejected through error/done, no bank is written.
  - Reads: error=1 with the 1-clock latency, and q0..q3 return 0.
- Undefined: upper address bits are ignored; every address aliases modulo 2^ADDR_BITS and never raises a range error.

Test Plan:
- Reset with rst=0 mid-COMMIT, then release -> q0..q3=0, done=0, error=0, state IDLE; a subsequent word write succeeds.
- Word write 0x11223344 at 0x010, then hold write=0 with address=0x010 -> done high one clock after COMMIT, drops the clock after write=0; q0..q3=11,22,33,44.
- Byte write d3=0xAA at 0x013, then read at 0x012 -> q0=0x33, q1=0xAA, q2 and q3 = bytes 0x014/0x015 (0x00 if unwritten, after writing 0 there).
- Half write at 0x011 -> error=1 and done=1 together, memory at 0x010..0x013 unchanged; both drop after write=0.
- Read at 0xFFE (ADDR_BITS=12) after word writes to 0xFFC and 0x000 -> q0,q1 from 0xFFE,0xFFF; q2,q3 from 0x000,0x001 (wrap).
- With RESP_BOUNDS_CHECK_EN: word write at 0x00001000 -> error=1, done=1, address 0x000 unchanged. Without the macro: the same write lands at 0x000, error=0.

Source files
------------

// File: rtl/byte_lane_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : byte_lane_mem_responder
// Purpose  : Memory-side responder for a byte-addressable memory port.
//            Storage is four 8-bit byte-lane banks, so a 4-byte read can start
//            at any byte address. Reads are registered every clock (1-clock
//            latency). Writes of 1/2/4 bytes use a level handshake: the
//            initiator holds `write` nonzero until `done` is seen.
// Ports    : clk          rising-edge clock
//            rst          asynchronous active-low reset
//            address[31:0] byte address A of the access
//            write[1:0]   0=read, 1=byte, 2=half, 3=word
//            d0..d3[7:0]  write data, d0 most significant
//            q0..q3[7:0]  read data, q0=byte A .. q3=byte A+3 (wraps)
//            done         write complete, held until write returns to 0
//            error        access rejected (misaligned / out of range)
// Options  : RESP_BOUNDS_CHECK_EN - when defined, addresses with any bit
//            above ADDR_BITS set are out of range (writes rejected, reads
//            return zero with error). When undefined, upper bits are ignored.
// Revision : 1.0 - initial release
// ============================================================================
module byte_lane_mem_responder #(
  parameter int ADDR_BITS = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] address,
  input  logic [1:0]  write,
  input  logic [7:0]  d0,
  input  logic [7:0]  d1,
  input  logic [7:0]  d2,
  input  logic [7:0]  d3,
  output logic [7:0]  q0,
  output logic [7:0]  q1,
  output logic [7:0]  q2,
  output logic [7:0]  q3,
  output logic        done,
  output logic        error
);

  localparam int ROW_BITS = ADDR_BITS - 2;
  localparam int ROWS     = 1 << ROW_BITS;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CHECK  = 2'd1,
    ST_COMMIT = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [ADDR_BITS-1:0] req_addr_q, req_addr_d;
  logic [1:0]           req_size_q, req_size_d;
  logic                 req_oor_q, req_oor_d;
  logic [7:0]           req_data_q [4];
  logic [7:0]           req_data_d [4];
  logic                 done_q, done_d;
  logic                 error_q, error_d;
  logic [7:0]           q_q [4];
  logic [7:0]           q_d [4];

  logic [ADDR_BITS-1:0] rd_addr;
  logic                 addr_oor;
  logic                 misaligned;
  logic [1:0]           wr_len;
  logic [7:0]           lane_rd [4];

  assign rd_addr = address[ADDR_BITS-1:0];

`ifdef RESP_BOUNDS_CHECK_EN
  assign addr_oor = |address[31:ADDR_BITS];
`else
  // Upper address bits alias onto the decoded range.
  logic unused_addr_hi;
  assign unused_addr_hi = ^address[31:ADDR_BITS];
  assign addr_oor       = 1'b0;
`endif

  assign misaligned = ((req_size_q == 2'd2) && req_addr_q[0]) ||
                      ((req_size_q == 2'd3) && (req_addr_q[1:0] != 2'd0));

  // Access length in bytes, modulo 4 (word encodes as 0).
  always_comb begin
    wr_len = 2'd0;
    case (req_size_q)
      2'd1:    wr_len = 2'd1;
      2'd2:    wr_len = 2'd2;
      default: wr_len = 2'd0;
    endcase
  end

  generate
    for (genvar l = 0; l < 4; l++) begin : g_lane
      localparam logic [1:0] LANE = 2'(l);

      logic [7:0]          mem [ROWS];
      logic [ROW_BITS-1:0] rd_row;
      logic [1:0]          wr_off;
      logic [1:0]          wr_idx;
      logic                wr_en;

      // Lanes below the starting lane hold bytes from the following row;
      // the row adder wraps naturally at the top of memory.
      assign rd_row     = rd_addr[ADDR_BITS-1:2] + ROW_BITS'(LANE < rd_addr[1:0]);
      assign lane_rd[l] = mem[rd_row];

      // Byte offset of this lane within the request, and which latched data
      // byte lands here: the access fills the last wr_len of d0..d3.
      assign wr_off = LANE - req_addr_q[1:0];
      assign wr_idx = wr_off - wr_len;

      always_comb begin
        wr_en = 1'b0;
        if (state_q == ST_COMMIT) begin
          case (req_size_q)
            2'd1:    wr_en = (wr_off == 2'd0);
            2'd2:    wr_en = ~wr_off[1];
            2'd3:    wr_en = 1'b1;
            default: wr_en = 1'b0;
          endcase
        end
      end

      // Aligned writes never cross a row, so every lane uses the request row.
      always_ff @(posedge clk) begin
        if (wr_en) begin
          mem[req_addr_q[ADDR_BITS-1:2]] <= req_data_q[wr_idx];
        end
      end
    end
  endgenerate

  // Read path: rotate lane outputs so q0 is byte A.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      q_d[k] = addr_oor ? 8'h00 : lane_rd[rd_addr[1:0] + 2'(k)];
    end
  end

  always_comb begin
    state_d    = state_q;
    req_addr_d = req_addr_q;
    req_size_d = req_size_q;
    req_oor_d  = req_oor_q;
    req_data_d = req_data_q;
    done_d     = done_q;
    error_d    = error_q;

    case (state_q)
      ST_IDLE: begin
        done_d  = 1'b0;
        error_d = addr_oor && (write == 2'd0);
        if (write != 2'd0) begin
          req_addr_d    = rd_addr;
          req_size_d    = write;
          req_oor_d     = addr_oor;
          req_data_d[0] = d0;
          req_data_d[1] = d1;
          req_data_d[2] = d2;
          req_data_d[3] = d3;
          state_d       = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (misaligned || req_oor_q) begin
          error_d = 1'b1;
          done_d  = 1'b1;
          state_d = ST_HOLD;
        end else begin
          state_d = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        done_d  = 1'b1;
        error_d = 1'b0;
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        // Only a return to zero ends the request; other values are ignored.
        if (write == 2'd0) begin
          done_d  = 1'b0;
          error_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        done_d  = 1'b0;
        error_d = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      req_addr_q <= '0;
      req_size_q <= 2'd0;
      req_oor_q  <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        req_data_q[k] <= 8'h00;
        q_q[k]        <= 8'h00;
      end
    end else begin
      state_q    <= state_d;
      req_addr_q <= req_addr_d;
      req_size_q <= req_size_d;
      req_oor_q  <= req_oor_d;
      done_q     <= done_d;
      error_q    <= error_d;
      for (int k = 0; k < 4; k++) begin
        req_data_q[k] <= req_data_d[k];
        q_q[k]        <= q_d[k];
      end
    end
  end

  assign q0    = q_q[0];
  assign q1    = q_q[1];
  assign q2    = q_q[2];
  assign q3    = q_q[3];
  assign done  = done_q;
  assign error = error_q;

endmodule
`default_nettype wire

// File: tb/tb_byte_lane_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_byte_lane_mem_responder
// Purpose  : Self-checking bench for byte_lane_mem_responder. A byte-level
//            reference memory predicts read data; expected read results are
//            queued when a read is driven and compared when q0..q3 update.
// Revision : 1.0 - initial release
// ============================================================================
module tb_byte_lane_mem_responder;

  localparam int AB = 12;

  typedef struct packed {
    logic [31:0] q;
    logic [31:0] mask;
    logic        err;
    logic [31:0] addr;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [31:0] address;
  logic [1:0]  write;
  logic [7:0]  d0, d1, d2, d3;
  logic [7:0]  q0, q1, q2, q3;
  logic        done, error;

  logic [7:0]  ref_mem [4096];
  logic        known   [4096];
  exp_t        sb [$];

  int n_checks;
  int n_errors;

  byte_lane_mem_responder #(.ADDR_BITS(AB)) dut (
    .clk     (clk),
    .rst     (rst),
    .address (address),
    .write   (write),
    .d0      (d0),
    .d1      (d1),
    .d2      (d2),
    .d3      (d3),
    .q0      (q0),
    .q1      (q1),
    .q2      (q2),
    .q3      (q3),
    .done    (done),
    .error   (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1);
  end

  function automatic logic out_of_range(input logic [31:0] a);
`ifdef RESP_BOUNDS_CHECK_EN
    return (a[31:AB] != '0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic bad_req(input logic [31:0] a, input logic [1:0] sz);
    logic b;
    b = ((sz == 2'd2) && a[0]) || ((sz == 2'd3) && (a[1:0] != 2'b00));
    return b || out_of_range(a);
  endfunction

  task automatic put(input logic [11:0] idx, input logic [7:0] v);
    ref_mem[idx] = v;
    known[idx]   = 1'b1;
  endtask

  task automatic model_write(input logic [31:0] a, input logic [1:0] sz,
                             input logic [31:0] data);
    logic [11:0] b;
    b = a[11:0];
    case (sz)
      2'd1: put(b, data[7:0]);
      2'd2: begin
        put(b, data[15:8]);
        put(b + 12'd1, data[7:0]);
      end
      2'd3: begin
        put(b,          data[31:24]);
        put(b + 12'd1,  data[23:16]);
        put(b + 12'd2,  data[15:8]);
        put(b + 12'd3,  data[7:0]);
      end
      default: ;
    endcase
  endtask

  // Drive a write at a negedge and run the full handshake.
  task automatic do_write(input logic [31:0] a, input logic [1:0] sz,
                          input logic [31:0] data, input logic wiggle);
    logic exp_err;
    int   exp_lat;
    int   lat;
    exp_err = bad_req(a, sz);
    exp_lat = exp_err ? 2 : 3;
    address = a;
    write   = sz;
    {d0, d1, d2, d3} = data;
    @(negedge clk);
    lat = 1;
    // Request is latched; these changes must be ignored.
    address = a ^ 32'h0000_0013;
    {d0, d1, d2, d3} = ~data;
    while (!done && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    n_checks++;
    if (lat !== exp_lat) begin
      n_errors++;
      $display("FAIL write_latency a=%h sz=%0d: got %0d cycles expected %0d", a, sz, lat, exp_lat);
    end
    n_checks++;
    if (error !== exp_err) begin
      n_errors++;
      $display("FAIL write_error a=%h sz=%0d: got %b expected %b", a, sz, error, exp_err);
    end
    if (!exp_err) model_write(a, sz, data);
    if (wiggle) begin
      write   = (sz == 2'd3) ? 2'd1 : 2'd3;
      address = a + 32'd4;
      repeat (2) @(negedge clk);
      n_checks++;
      if ({done, error} !== {1'b1, exp_err}) begin
        n_errors++;
        $display("FAIL hold_stable a=%h: got done/err %b%b expected %b%b", a, done, error, 1'b1, exp_err);
      end
    end
    write   = 2'd0;
    address = 32'h0;
    @(negedge clk);
    n_checks++;
    if ({done, error} !== 2'b00) begin
      n_errors++;
      $display("FAIL write_release a=%h: got done/err %b%b expected 00", a, done, error);
    end
  endtask

  // Drive a read at a negedge; expectation queued now, checked one clock later.
  task automatic do_read(input logic [31:0] a);
    exp_t        e;
    logic [11:0] idx;
    e.addr = a;
    e.err  = out_of_range(a);
    e.q    = '0;
    e.mask = '0;
    for (int k = 0; k < 4; k++) begin
      idx = a[11:0] + 12'(k);
      if (e.err) begin
        e.mask[31-8*k -: 8] = 8'hFF;
      end else if (known[idx]) begin
        e.q[31-8*k -: 8]    = ref_mem[idx];
        e.mask[31-8*k -: 8] = 8'hFF;
      end
    end
    sb.push_back(e);
    address = a;
    write   = 2'd0;
    @(negedge clk);
    e = sb.pop_front();
    n_checks++;
    if (({q0, q1, q2, q3} & e.mask) !== e.q) begin
      n_errors++;
      $display("FAIL read_data a=%h: got %h expected %h (mask %h)", e.addr, {q0, q1, q2, q3}, e.q, e.mask);
    end
    n_checks++;
    if (error !== e.err) begin
      n_errors++;
      $display("FAIL read_error a=%h: got %b expected %b", e.addr, error, e.err);
    end
  endtask

  task automatic test_reset;
    rst     = 1'b0;
    address = 32'h0;
    write   = 2'd0;
    {d0, d1, d2, d3} = 32'h0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({q0, q1, q2, q3} !== 32'h0) begin
      n_errors++;
      $display("FAIL reset_q: got %h expected 00000000", {q0, q1, q2, q3});
    end
    n_checks++;
    if ({done, error} !== 2'b00) begin
      n_errors++;
      $display("FAIL reset_flags: got done/err %b%b expected 00", done, error);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_word_write;
    do_write(32'h010, 2'd3, 32'h11223344, 1'b0);
    do_read(32'h010);
  endtask

  task automatic test_byte_write;
    do_write(32'h014, 2'd3, 32'h00000000, 1'b0);
    do_write(32'h013, 2'd1, 32'h5566_77AA, 1'b0);
    do_read(32'h012);
    do_read(32'h013);
  endtask

  task automatic test_misaligned;
    do_write(32'h011, 2'd2, 32'h0000_BEEF, 1'b0);
    do_read(32'h010);
    do_write(32'h012, 2'd3, 32'hCAFEF00D, 1'b0);
    do_write(32'h012, 2'd2, 32'h0000_9988, 1'b0);
    do_read(32'h010);
  endtask

  task automatic test_wrap;
    do_write(32'hFFC, 2'd3, 32'hA1A2A3A4, 1'b0);
    do_write(32'h000, 2'd3, 32'hB1B2B3B4, 1'b0);
    do_read(32'hFFE);
    do_read(32'hFFF);
  endtask

  task automatic test_bounds;
    do_write(32'h0000_1000, 2'd3, 32'hC1C2C3C4, 1'b0);
    do_read(32'h000);
    do_read(32'h0000_1000);
  endtask

  task automatic test_reset_mid_commit;
    logic [11:0] idx;
    address = 32'h020;
    write   = 2'd3;
    {d0, d1, d2, d3} = 32'h0BADF00D;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if ({q0, q1, q2, q3, done, error} !== 34'h0) begin
      n_errors++;
      $display("FAIL reset_mid_commit: got q=%h done/err %b%b expected 0 00", {q0, q1, q2, q3}, done, error);
    end
    for (int k = 0; k < 4; k++) begin
      idx = 12'h020 + 12'(k);
      known[idx] = 1'b0;
    end
    @(negedge clk);
    write = 2'd0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    do_write(32'h020, 2'd3, 32'hDEADBEEF, 1'b0);
    do_read(32'h020);
  endtask

  task automatic test_back_to_back;
    logic [31:0] a;
    logic [1:0]  sz;
    do_write(32'h100, 2'd3, 32'h01020304, 1'b1);
    do_write(32'h104, 2'd2, 32'h0000_0506, 1'b1);
    do_read(32'h100);
    for (int i = 0; i < 14; i++) begin
      sz = 2'($urandom_range(1, 3));
      a  = 32'h100 + 32'($urandom_range(0, 31));
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd3) a[1:0] = 2'b00;
        if (sz == 2'd2) a[0]   = 1'b0;
      end
      do_write(a, sz, $urandom, 1'($urandom_range(0, 1)));
      do_read(a);
      do_read(32'h100 + 32'($urandom_range(0, 31)));
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    for (int i = 0; i < 4096; i++) begin
      ref_mem[i] = 8'h00;
      known[i]   = 1'b0;
    end
    test_reset();
    test_word_write();
    test_byte_write();
    test_misaligned();
    test_wrap();
    test_bounds();
    test_reset_mid_commit();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
